stream_cipher: RTL and testbench
================================

// Module: stream_cipher
// PURPOSE
//  Byte-serial symmetric stream cipher for the datapath: XORs each valid input byte with a keystream byte.
//  The keystream comes from a 32-bit LFSR seeded by a 32-bit key at the start of each message.
//  Encryption and decryption are the same operation; the encrypt flag travels through the pipeline alongside the data.
//  Fixed 3-cycle latency, one byte per clock, no backpressure.
// PARAMETERS
//  LATENCY    3               input-sample edge to output-update edge; fixed, for benches only
//  LFSR_MASK  32'h8020_0003   right-shift Galois taps, x^32+x^22+x^2+x+1
//  ZERO_SUB   32'hFFFF_FFFF   seed used in place of key==0 (avoids LFSR lock-up)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  data_in      in   8   plaintext (encrypt) or ciphertext (decrypt) byte
//  valid_in     in   1   data_in/new_message/encrypt_in/key are sampled this cycle
//  key          in   32  message key; used only when valid_in & new_message
//  new_message  in   1   this byte is byte 0 of a new message; reseed from key
//  encrypt_in   in   1   1=encrypt, 0=decrypt; passed through only, no effect on datapath
//  data_out     out  8   data_in ^ keystream byte
//  encrypt_out  out  1   encrypt_in of the same byte
//  valid_out    out  1   data_out/encrypt_out are valid this cycle
// BEHAVIOUR
//  Interface constraint (already decided): one clock; reset is asynchronous and active-low.
//  Reset: data_out=0, encrypt_out=0, valid_out=0, all pipeline valids=0, keystream state S=ZERO_SUB.
//  Per accepted byte (valid_in=1 at a rising edge):
//   - Seed selection: Sc = new_message ? ((key==0) ? ZERO_SUB : key) : S.
//   - Keystream byte: k = Sc[31:24] ^ Sc[7:0].
//   - State update: S <= step8(Sc), i.e. 8 right-shift Galois steps.
//     Each step: s = s[0] ? ((s>>1) ^ LFSR_MASK) : (s>>1).
//   - Output: data_out = data_in ^ k.
//  valid_in=0: S holds; new_message/key/encrypt_in are ignored; no output is generated.
//  Back-to-back new_message is legal; each such byte reuses keystream byte 0 of its key.
//  Latency: a byte sampled at edge N updates data_out/encrypt_out/valid_out at edge N+3.
//  Throughput: 1 byte/clk; every stage advances every cycle (no stall).
//  valid_out is 0 in every other cycle; data_out/encrypt_out hold their last value when valid_out=0.
//  Pipeline registers:
//   - stage1 captures inputs;
//   - stage2 computes Sc, k and the S update;
//   - stage3 XORs and drives the outputs.
//  S is read and written only in stage2, so consecutive bytes chain correctly.
//  Mixed encrypt/decrypt bytes may be interleaved; results stay in order.
//  Reset mid-operation clears the pipeline immediately; in-flight bytes are lost (valid_out=0).
//  Decryption is the identical XOR, so enc(key, P) fed back with the same key and position yields P.
// STRUCTURE
//  stream_cipher_pkg: LFSR_MASK, ZERO_SUB, function lfsr_step8(logic [31:0]), function ks_byte(logic [31:0]).
//  Sub-module stream_cipher_keygen: owns S and the seed mux.
//   - Inputs: advance, reseed, key.
//   - Outputs: ks byte (registered into stage3).
//  Top level: input/output registers, valid/encrypt shift pipe, XOR.
// TESTING
//  1 Seed: key=32'h0000_0001, new_message, data_in 00 then 00 on consecutive cycles
//    -> data_out 01 then D9 (S after byte0 = DB36C002), encrypt_out=1, 3 cycles latency.
//  2 Round trip: encrypt 8 bytes with key K, then decrypt those outputs with new_message and key K
//    -> original 8 bytes returned, encrypt_out=0.
//  3 Gaps: same 8-byte message with valid_in pulsed every other cycle
//    -> identical data_out sequence; valid_out pulses exactly 3 cycles after each input.
//  4 Interleave: enc byte with new_message (key K), then a dec byte with new_message (key K) on the next cycle
//    -> outputs on consecutive cycles, both XORed with keystream byte 0 of K; encrypt_out 1 then 0.
//  5 Zero key: key=0 and key=FFFF_FFFF -> identical ciphertexts.
//  6 Reset: assert rst_n=0 with 2 bytes in flight -> valid_out=0 at once; after release the first output is 3 cycles after the next valid_in.

Source files
------------

// File: rtl/stream_cipher_pkg.sv
// Shared constants and keystream helpers for the byte-serial stream cipher.
// Latency: n/a (package only).
// Backpressure: n/a.
package stream_cipher_pkg;

    // Input-sample edge to output-update edge.
    localparam int          LATENCY   = 3;
    // Right-shift Galois taps for x^32+x^22+x^2+x+1.
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    // An all-zero state would lock the LFSR, so key==0 seeds with this instead.
    localparam logic [31:0] ZERO_SUB  = 32'hFFFF_FFFF;

    // Byte plus its encrypt flag, carried together down the pipe.
    typedef struct packed {
        logic [7:0] dat;
        logic       enc;
    } byte_meta_t;

    // Eight right-shift Galois steps: one keystream byte's worth of advance.
    function automatic logic [31:0] lfsr_step8(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ LFSR_MASK) : (r >> 1);
        end
        return r;
    endfunction

    // Keystream byte taken from the current state before it advances.
    function automatic logic [7:0] ks_byte(input logic [31:0] s);
        return s[31:24] ^ s[7:0];
    endfunction

endpackage

// File: rtl/stream_cipher_if.sv
// Byte stream in/out bundle for the stream cipher.
// Latency: n/a (wires only).
// Backpressure: none; valid_in/valid_out are plain strobes.
interface stream_cipher_if;

    logic [7:0]  data_in;
    logic        valid_in;
    logic [31:0] key;
    logic        new_message;
    logic        encrypt_in;
    logic [7:0]  data_out;
    logic        encrypt_out;
    logic        valid_out;

    // master drives bytes in and receives results
    modport master (
        output data_in, valid_in, key, new_message, encrypt_in,
        input  data_out, encrypt_out, valid_out
    );

    // slave is the cipher itself
    modport slave (
        input  data_in, valid_in, key, new_message, encrypt_in,
        output data_out, encrypt_out, valid_out
    );

endinterface

// File: rtl/stream_cipher_keygen.sv
// Keystream generator: owns LFSR state S and the seed mux, emits one keystream byte per advance.
// Latency: 1 cycle, advance at edge N gives ks_dat after edge N.
// Backpressure: none; S moves only on advance, holds otherwise.
// Ports: clk, rst_n; advance (consume one byte), reseed (start of message), key; ks_dat (registered).
import stream_cipher_pkg::*;

module stream_cipher_keygen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    input  logic        reseed,
    input  logic [31:0] key,
    output logic [7:0]  ks_dat
);

    logic [31:0] s_q;
    logic [31:0] key_seed;
    logic [31:0] sc;

    // S is both read and written here, so back-to-back bytes chain without a bypass.
    always_comb begin
        key_seed = (key == 32'h0) ? ZERO_SUB : key;
        sc       = reseed ? key_seed : s_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= ZERO_SUB;
            ks_dat <= 8'h00;
        end else if (advance) begin
            s_q    <= lfsr_step8(sc);
            ks_dat <= ks_byte(sc);
        end
    end

endmodule

// File: rtl/stream_cipher.sv
// Byte-serial stream cipher: data_out = data_in ^ LFSR keystream byte; encrypt flag rides along.
// Latency: 3 cycles, byte sampled at edge N updates outputs at edge N+3; one byte per clock.
// Backpressure: none; every stage advances every cycle.
// Ports: clk, rst_n; bus (slave) carries data/valid/key/new_message/encrypt in and data/encrypt/valid out.
import stream_cipher_pkg::*;

module stream_cipher (
    input  logic            clk,
    input  logic            rst_n,
    stream_cipher_if.slave  bus
);

    // stage1: input capture (edge N)
    logic        s1_vld;
    logic        s1_nm;
    logic [31:0] s1_key;
    byte_meta_t  s1_dat;

    // stage2: keystream byte registered in keygen, data delayed alongside (edge N+1)
    logic        s2_vld;
    byte_meta_t  s2_dat;
    logic [7:0]  ks_dat;

    // stage3: XOR result (edge N+2); output registers take it at edge N+3
    logic        s3_vld;
    byte_meta_t  s3_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_nm  <= 1'b0;
            s1_key <= 32'h0;
            s1_dat <= '0;
        end else begin
            s1_vld <= bus.valid_in;
            // Sideband is only meaningful with valid_in; skip the capture otherwise.
            if (bus.valid_in) begin
                s1_nm      <= bus.new_message;
                s1_key     <= bus.key;
                s1_dat.dat <= bus.data_in;
                s1_dat.enc <= bus.encrypt_in;
            end
        end
    end

    stream_cipher_keygen u_keygen (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (s1_vld),
        .reseed  (s1_nm),
        .key     (s1_key),
        .ks_dat  (ks_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld <= 1'b0;
            s2_dat <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_dat <= s1_dat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_vld <= 1'b0;
            s3_dat <= '0;
        end else begin
            s3_vld <= s2_vld;
            if (s2_vld) begin
                s3_dat.dat <= s2_dat.dat ^ ks_dat;
                s3_dat.enc <= s2_dat.enc;
            end
        end
    end

    // Outputs hold their last value between valid bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.valid_out   <= 1'b0;
            bus.data_out    <= 8'h00;
            bus.encrypt_out <= 1'b0;
        end else begin
            bus.valid_out <= s3_vld;
            if (s3_vld) begin
                bus.data_out    <= s3_dat.dat;
                bus.encrypt_out <= s3_dat.enc;
            end
        end
    end

endmodule

// File: tb/tb_stream_cipher.sv
module tb_stream_cipher;
    import stream_cipher_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stream_cipher_if bus();

    stream_cipher dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Hand-computed keystream for key=1: S0=00000001, S1=DB36C002, S2=B6F6B6C3, S3=2DBDB6B6
    // -> k = 01, D9, 75, 9B. Plaintext 00,11,22,33 gives these ciphertexts.
    logic [7:0] plain  [8] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    logic [7:0] ct_key1[4] = '{8'h01, 8'hC8, 8'h57, 8'hA8};

    // Drive one input slot; the slot is sampled at the following rising edge.
    task automatic drive(input logic v, input logic [7:0] d, input logic nm,
                         input logic [31:0] k, input logic e);
        @(negedge clk);
        bus.valid_in    = v;
        bus.data_in     = d;
        bus.new_message = nm;
        bus.key         = k;
        bus.encrypt_in  = e;
    endtask

    // Loop convention: iteration t drives slot t and observes the result of slot t-LATENCY-1.

    task automatic test_reset();
        bus.valid_in = 1'b0; bus.data_in = 8'h00; bus.new_message = 1'b0;
        bus.key = 32'h0; bus.encrypt_in = 1'b0;
        rst_n = 1'b0;
        #22;
        checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.valid_out); end
        checks++; if (bus.data_out !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", bus.data_out); end
        checks++; if (bus.encrypt_out !== 1'b0) begin failures++; $display("FAIL rst_enc got=%b exp=0", bus.encrypt_out); end
        @(negedge clk);
        rst_n = 1'b1;
        // No new_message: S must be ZERO_SUB, whose keystream byte is FF^FF = 00.
        for (int t = 0; t < 7; t++) begin
            drive(t == 0, 8'h3C, 1'b0, 32'h1234_5678, 1'b1);
            if (t >= 1) begin
                checks++;
                if (bus.valid_out !== (t == LATENCY + 1)) begin failures++; $display("FAIL rst_s_valid t=%0d got=%b exp=%b", t, bus.valid_out, (t == LATENCY + 1)); end
            end
            if (t == LATENCY + 1) begin
                checks++; if (bus.data_out !== 8'h3C) begin failures++; $display("FAIL rst_s_data got=%h exp=3C", bus.data_out); end
            end
        end
    endtask

    task automatic test_seed();
        for (int t = 0; t < 8; t++) begin
            drive(t < 2, 8'h00, t == 0, 32'h0000_0001, 1'b1);
            if (t >= 1) begin
                checks++;
                if (bus.valid_out !== (t == 4 || t == 5)) begin failures++; $display("FAIL seed_valid t=%0d got=%b exp=%b", t, bus.valid_out, (t == 4 || t == 5)); end
            end
            if (t == 4) begin
                checks++; if (bus.data_out !== 8'h01) begin failures++; $display("FAIL seed_b0 got=%h exp=01", bus.data_out); end
                checks++; if (bus.encrypt_out !== 1'b1) begin failures++; $display("FAIL seed_enc got=%b exp=1", bus.encrypt_out); end
            end
            if (t == 5) begin
                checks++; if (bus.data_out !== 8'hD9) begin failures++; $display("FAIL seed_b1 got=%h exp=D9", bus.data_out); end
            end
        end
    endtask

    task automatic test_round_trip();
        logic [7:0] ct[8];
        for (int t = 0; t < 12; t++) begin
            drive(t < 8, plain[t % 8], t == 0, 32'h0000_0001, 1'b1);
            if (t >= 4) begin
                checks++; if (bus.valid_out !== 1'b1) begin failures++; $display("FAIL rt_enc_valid t=%0d got=%b exp=1", t, bus.valid_out); end
                checks++; if (bus.encrypt_out !== 1'b1) begin failures++; $display("FAIL rt_enc_flag t=%0d got=%b exp=1", t, bus.encrypt_out); end
                ct[t - 4] = bus.data_out;
                if (t < 8) begin
                    checks++;
                    if (bus.data_out !== ct_key1[t - 4]) begin failures++; $display("FAIL rt_enc_data i=%0d got=%h exp=%h", t - 4, bus.data_out, ct_key1[t - 4]); end
                end
            end
        end
        for (int t = 0; t < 12; t++) begin
            drive(t < 8, ct[t % 8], t == 0, 32'h0000_0001, 1'b0);
            if (t >= 4) begin
                checks++; if (bus.valid_out !== 1'b1) begin failures++; $display("FAIL rt_dec_valid t=%0d got=%b exp=1", t, bus.valid_out); end
                checks++; if (bus.encrypt_out !== 1'b0) begin failures++; $display("FAIL rt_dec_flag t=%0d got=%b exp=0", t, bus.encrypt_out); end
                checks++; if (bus.data_out !== plain[t - 4]) begin failures++; $display("FAIL rt_dec_data i=%0d got=%h exp=%h", t - 4, bus.data_out, plain[t - 4]); end
            end
        end
    endtask

    task automatic test_gaps();
        for (int t = 0; t < 21; t++) begin
            drive((t % 2 == 0) && (t < 16), plain[(t / 2) % 8], t == 0, 32'h0000_0001, 1'b1);
            if (t >= 4) begin
                int s;
                logic exp_v;
                s = t - 4;
                exp_v = (s % 2 == 0) && (s < 16);
                checks++;
                if (bus.valid_out !== exp_v) begin failures++; $display("FAIL gap_valid t=%0d got=%b exp=%b", t, bus.valid_out, exp_v); end
                if (exp_v && (s / 2) < 4) begin
                    checks++;
                    if (bus.data_out !== ct_key1[s / 2]) begin failures++; $display("FAIL gap_data i=%0d got=%h exp=%h", s / 2, bus.data_out, ct_key1[s / 2]); end
                end
            end
        end
    endtask

    task automatic test_interleave();
        for (int t = 0; t < 8; t++) begin
            if (t == 0)      drive(1'b1, 8'hA5, 1'b1, 32'h0000_0001, 1'b1);
            else if (t == 1) drive(1'b1, 8'h3C, 1'b1, 32'h0000_0001, 1'b0);
            else             drive(1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
            if (t >= 1) begin
                checks++;
                if (bus.valid_out !== (t == 4 || t == 5)) begin failures++; $display("FAIL il_valid t=%0d got=%b exp=%b", t, bus.valid_out, (t == 4 || t == 5)); end
            end
            if (t == 4) begin
                checks++; if (bus.data_out !== 8'hA4) begin failures++; $display("FAIL il_enc_data got=%h exp=A4", bus.data_out); end
                checks++; if (bus.encrypt_out !== 1'b1) begin failures++; $display("FAIL il_enc_flag got=%b exp=1", bus.encrypt_out); end
            end
            if (t == 5) begin
                checks++; if (bus.data_out !== 8'h3D) begin failures++; $display("FAIL il_dec_data got=%h exp=3D", bus.data_out); end
                checks++; if (bus.encrypt_out !== 1'b0) begin failures++; $display("FAIL il_dec_flag got=%b exp=0", bus.encrypt_out); end
            end
        end
    endtask

    // key=0 and key=FFFFFFFF share keystream 00, B7 (S1 = 49EDBFFE).
    task automatic test_zero_key();
        logic [7:0] exp_d[4] = '{8'h5A, 8'hED, 8'h5A, 8'hED};
        for (int t = 0; t < 9; t++) begin
            drive(t < 4, 8'h5A, (t == 0) || (t == 2), (t < 2) ? 32'h0 : 32'hFFFF_FFFF, 1'b1);
            if (t >= 4 && t < 8) begin
                checks++; if (bus.valid_out !== 1'b1) begin failures++; $display("FAIL zk_valid t=%0d got=%b exp=1", t, bus.valid_out); end
                checks++; if (bus.data_out !== exp_d[t - 4]) begin failures++; $display("FAIL zk_data i=%0d got=%h exp=%h", t - 4, bus.data_out, exp_d[t - 4]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int t = 0; t < 5; t++) begin
            drive(t < 4, 8'h00, t == 0, 32'h0000_0001, 1'b1);
        end
        drive(1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
        checks++; if (bus.valid_out !== 1'b1) begin failures++; $display("FAIL rm_pre_valid got=%b exp=1", bus.valid_out); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b exp=0", bus.valid_out); end
        checks++; if (bus.data_out !== 8'h00) begin failures++; $display("FAIL rm_data got=%h exp=00", bus.data_out); end
        drive(1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            drive(1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
            checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL rm_lost t=%0d got=%b exp=0", t, bus.valid_out); end
        end
        for (int t = 0; t < 7; t++) begin
            drive(t == 0, 8'h10, t == 0, 32'h0000_0001, 1'b1);
            if (t >= 1) begin
                checks++;
                if (bus.valid_out !== (t == 4)) begin failures++; $display("FAIL rm_post_valid t=%0d got=%b exp=%b", t, bus.valid_out, (t == 4)); end
            end
            if (t == 4) begin
                checks++; if (bus.data_out !== 8'h11) begin failures++; $display("FAIL rm_post_data got=%h exp=11", bus.data_out); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_seed();
        test_round_trip();
        test_gaps();
        test_interleave();
        test_zero_key();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
